// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback control FSM for the NPC core.
// Optional performance counters are enabled by defining EXEC_SEQ_PERF_EN.
module exec_sequencer #(
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10,
  parameter int PERF_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ifu_req,
  input  logic              ifu_valid,
  output logic              ir_we,
  input  logic [3:0]        alu_ctrl,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              is_branch,
  input  logic              is_jump,
  input  logic              is_ebreak,
  input  logic              br_taken,
  output logic              mdu_start,
  input  logic              mdu_done,
  output logic              lsu_req,
  output logic              lsu_we,
  input  logic              lsu_ack,
  output logic              rf_we,
  output logic              pc_we,
  output logic              pc_sel,
  output logic              halt,
  output logic [1:0]        halt_code,
  output logic [2:0]        state_o
`ifdef EXEC_SEQ_PERF_EN
  ,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [1:0] HC_EBREAK  = 2'd0;
  localparam logic [1:0] HC_ILLEGAL = 2'd1;
  localparam logic [1:0] HC_TIMEOUT = 2'd2;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

  if (TIMEOUT < 1 || TIMEOUT >= (1 << TO_W) || PERF_W < 1) begin : g_bad_param
    $error("exec_sequencer: TIMEOUT must lie in 1..2**TO_W-1 and PERF_W must be >= 1");
  end

  state_e          state_q, state_d;
  logic [1:0]      halt_code_q, halt_code_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic            load_q, load_d;
  logic            store_q, store_d;
  logic            branch_q, branch_d;
  logic            jump_q, jump_d;
  logic            mdu_busy_q, mdu_busy_d;

  logic mdu_op;
  logic waiting;
  logic expire;

  assign mdu_op = (ctrl_q == 4'd3) || (ctrl_q == 4'd5);

  // mdu_busy_q is low only in the start cycle, so mdu_done is not sampled there.
  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM) ||
                   ((state_q == S_EXEC) && mdu_op && mdu_busy_q);
  assign expire  = waiting && (wd_q == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      halt_code_q <= 2'd0;
      wd_q        <= '0;
      ctrl_q      <= 4'd0;
      load_q      <= 1'b0;
      store_q     <= 1'b0;
      branch_q    <= 1'b0;
      jump_q      <= 1'b0;
      mdu_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_code_q <= halt_code_d;
      wd_q        <= wd_d;
      ctrl_q      <= ctrl_d;
      load_q      <= load_d;
      store_q     <= store_d;
      branch_q    <= branch_d;
      jump_q      <= jump_d;
      mdu_busy_q  <= mdu_busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    halt_code_d = halt_code_q;
    ctrl_d      = ctrl_q;
    load_d      = load_q;
    store_d     = store_q;
    branch_d    = branch_q;
    jump_d      = jump_q;
    mdu_busy_d  = (state_q == S_EXEC) && mdu_op;

    if (state_q == S_DECODE) begin
      ctrl_d   = alu_ctrl;
      load_d   = is_load;
      store_d  = is_store;
      branch_d = is_branch;
      jump_d   = is_jump;
    end

    // Handshakes are tested before expiry so a same-cycle arrival wins.
    case (state_q)
      S_FETCH: begin
        if (ifu_valid) begin
          state_d = S_DECODE;
        end else if (expire) begin
          state_d     = S_HALT;
          halt_code_d = HC_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (is_ebreak) begin
          state_d     = S_HALT;
          halt_code_d = HC_EBREAK;
        end else if ((alu_ctrl == 4'hF) && !(is_store || is_branch || is_jump)) begin
          state_d     = S_HALT;
          halt_code_d = HC_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!mdu_op || (mdu_busy_q && mdu_done)) begin
          state_d = (load_q || store_q) ? S_MEM : S_WB;
        end else if (expire) begin
          state_d     = S_HALT;
          halt_code_d = HC_TIMEOUT;
        end
      end
      S_MEM: begin
        if (lsu_ack) begin
          state_d = S_WB;
        end else if (expire) begin
          state_d     = S_HALT;
          halt_code_d = HC_TIMEOUT;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    if (state_d != state_q) begin
      wd_d = '0;
    end else if (waiting) begin
      wd_d = wd_q + TO_W'(1);
    end else begin
      wd_d = wd_q;
    end
  end

  always_comb begin
    ifu_req   = 1'b0;
    ir_we     = 1'b0;
    mdu_start = 1'b0;
    lsu_req   = 1'b0;
    lsu_we    = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    halt      = 1'b0;
    halt_code = halt_code_q;
    state_o   = state_q;
    case (state_q)
      S_FETCH: begin
        ifu_req = 1'b1;
        ir_we   = ifu_valid;
      end
      S_EXEC:  mdu_start = mdu_op && !mdu_busy_q;
      S_MEM: begin
        lsu_req = 1'b1;
        lsu_we  = store_q;
      end
      S_WB: begin
        pc_we  = 1'b1;
        pc_sel = jump_q || (branch_q && br_taken);
        rf_we  = !(store_q || branch_q);
      end
      S_HALT:  halt = 1'b1;
      default: ;
    endcase
  end

`ifdef EXEC_SEQ_PERF_EN
  logic [PERF_W-1:0] cycle_q, cycle_d;
  logic [PERF_W-1:0] instret_q, instret_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    cycle_d   = (state_q != S_HALT) ? cycle_q + PERF_W'(1) : cycle_q;
    instret_d = (state_q == S_WB) ? instret_q + PERF_W'(1) : instret_q;
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: per-cycle expected output vectors are queued
// by the driver and compared by an independent negedge monitor.
module tb_exec_sequencer;

  localparam int W = 14;

  localparam logic [4:0] CL_NONE  = 5'b00000;
  localparam logic [4:0] CL_LOAD  = 5'b10000;
  localparam logic [4:0] CL_STORE = 5'b01000;
  localparam logic [4:0] CL_BR    = 5'b00100;
  localparam logic [4:0] CL_JMP   = 5'b00010;
  localparam logic [4:0] CL_EBR   = 5'b00001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ifu_valid = 1'b0;
  logic [3:0] alu_ctrl = 4'd0;
  logic       is_load = 1'b0, is_store = 1'b0, is_branch = 1'b0, is_jump = 1'b0, is_ebreak = 1'b0;
  logic       br_taken = 1'b0, mdu_done = 1'b0, lsu_ack = 1'b0;
  logic       ifu_req, ir_we, mdu_start, lsu_req, lsu_we, rf_we, pc_we, pc_sel, halt;
  logic [1:0] halt_code;
  logic [2:0] state_o;
`ifdef EXEC_SEQ_PERF_EN
  logic [63:0] cycle_cnt, instret_cnt;
`endif

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           errors = 0;

  exec_sequencer #(.TIMEOUT(8), .TO_W(10), .PERF_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req(ifu_req), .ifu_valid(ifu_valid), .ir_we(ir_we),
    .alu_ctrl(alu_ctrl),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
    .is_jump(is_jump), .is_ebreak(is_ebreak), .br_taken(br_taken),
    .mdu_start(mdu_start), .mdu_done(mdu_done),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_ack(lsu_ack),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .halt(halt), .halt_code(halt_code), .state_o(state_o)
`ifdef EXEC_SEQ_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: sim time %0t exceeded bound", $time);
    $fatal(1);
  end

  // Expected-vector builders: {state, ifu_req, ir_we, mdu_start, lsu_req, lsu_we,
  // rf_we, pc_we, pc_sel, halt, halt_code}
  function automatic logic [W-1:0] ev(input logic [2:0] st, input logic ir, input logic ms,
                                      input logic lr, input logic lw, input logic rf,
                                      input logic pw, input logic ps, input logic [1:0] hc);
    return {st, (st == 3'd0), ir, ms, lr, lw, rf, pw, ps, (st == 3'd5), hc};
  endfunction

  function automatic logic [W-1:0] e_f(input logic ir);
    return ev(3'd0, ir, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endfunction
  function automatic logic [W-1:0] e_d();
    return ev(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endfunction
  function automatic logic [W-1:0] e_x(input logic ms);
    return ev(3'd2, 1'b0, ms, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endfunction
  function automatic logic [W-1:0] e_m(input logic lw);
    return ev(3'd3, 1'b0, 1'b0, 1'b1, lw, 1'b0, 1'b0, 1'b0, 2'd0);
  endfunction
  function automatic logic [W-1:0] e_wb(input logic rf, input logic ps);
    return ev(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, rf, 1'b1, ps, 2'd0);
  endfunction
  function automatic logic [W-1:0] e_h(input logic [1:0] hc);
    return ev(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, hc);
  endfunction

  function automatic logic [W-1:0] act_vec();
    return {state_o, ifu_req, ir_we, mdu_start, lsu_req, lsu_we, rf_we, pc_we, pc_sel, halt, halt_code};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      string        t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, {50'd0, act_vec()}, {50'd0, e});
    end
  end

  // Driver tasks
  task automatic step(input logic iv, input logic [3:0] ac, input logic [4:0] cl,
                      input logic bt, input logic md, input logic la,
                      input logic [W-1:0] e, input string t);
    @(posedge clk);
    #1;
    ifu_valid = iv;
    alu_ctrl  = ac;
    {is_load, is_store, is_branch, is_jump, is_ebreak} = cl;
    br_taken  = bt;
    mdu_done  = md;
    lsu_ack   = la;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic do_reset(input logic iv0);
    @(negedge clk);
    #1;
    rst_n     = 1'b0;
    ifu_valid = iv0;
    alu_ctrl  = 4'd0;
    {is_load, is_store, is_branch, is_jump, is_ebreak} = CL_NONE;
    br_taken  = 1'b0;
    mdu_done  = 1'b0;
    lsu_ack   = 1'b0;
    #2;
    chk("rst_state", {61'd0, state_o}, 64'd0);
    chk("rst_ifu_req", {63'd0, ifu_req}, 64'd1);
    chk("rst_outs", {55'd0, mdu_start, lsu_req, lsu_we, rf_we, pc_we, pc_sel, halt, halt_code},
        64'd0);
`ifdef EXEC_SEQ_PERF_EN
    chk("rst_perf", cycle_cnt | instret_cnt, 64'd0);
`endif
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset(1'b0);

    // addi: F D E WB
    step(1, 4'd0, CL_NONE, 0, 0, 0, e_f(1),       "addi_f");
    step(0, 4'd0, CL_NONE, 0, 0, 0, e_d(),        "addi_d");
    step(0, 4'd0, CL_NONE, 0, 0, 0, e_x(0),       "addi_e");
    step(0, 4'd0, CL_NONE, 0, 0, 0, e_wb(1, 0),   "addi_wb");
    // mul: done held in start cycle (ignored), real done 3 cycles after start
    step(1, 4'd5, CL_NONE, 0, 0, 0, e_f(1),       "mul_f");
    step(0, 4'd5, CL_NONE, 0, 0, 0, e_d(),        "mul_d");
    step(0, 4'd5, CL_NONE, 0, 1, 0, e_x(1),       "mul_e1");
    step(0, 4'd5, CL_NONE, 0, 0, 0, e_x(0),       "mul_e2");
    step(0, 4'd5, CL_NONE, 0, 0, 0, e_x(0),       "mul_e3");
    step(0, 4'd5, CL_NONE, 0, 1, 0, e_x(0),       "mul_e4");
    step(0, 4'd5, CL_NONE, 0, 0, 0, e_wb(1, 0),   "mul_wb");
    // div with done right after the start cycle
    step(1, 4'd3, CL_NONE, 0, 1, 0, e_f(1),       "div_f");
    step(0, 4'd3, CL_NONE, 0, 1, 0, e_d(),        "div_d");
    step(0, 4'd3, CL_NONE, 0, 1, 0, e_x(1),       "div_e1");
    step(0, 4'd3, CL_NONE, 0, 1, 0, e_x(0),       "div_e2");
    step(0, 4'd3, CL_NONE, 0, 0, 0, e_wb(1, 0),   "div_wb");
    // sd: ack on third MEM cycle
    step(1, 4'd0, CL_STORE, 0, 0, 0, e_f(1),      "sd_f");
    step(0, 4'd0, CL_STORE, 0, 0, 0, e_d(),       "sd_d");
    step(0, 4'd0, CL_STORE, 0, 0, 0, e_x(0),      "sd_e");
    step(0, 4'd0, CL_STORE, 0, 0, 0, e_m(1),      "sd_m1");
    step(0, 4'd0, CL_STORE, 0, 0, 0, e_m(1),      "sd_m2");
    step(0, 4'd0, CL_STORE, 0, 0, 1, e_m(1),      "sd_m3");
    step(0, 4'd0, CL_STORE, 0, 0, 0, e_wb(0, 0),  "sd_wb");
    // beq taken
    step(1, 4'd2, CL_BR, 0, 0, 0, e_f(1),         "beq_f");
    step(0, 4'd2, CL_BR, 0, 0, 0, e_d(),          "beq_d");
    step(0, 4'd2, CL_BR, 0, 0, 0, e_x(0),         "beq_e");
    step(0, 4'd2, CL_BR, 1, 0, 0, e_wb(0, 1),     "beq_wb");
    // bne not taken
    step(1, 4'd2, CL_BR, 0, 0, 0, e_f(1),         "bne_f");
    step(0, 4'd2, CL_BR, 0, 0, 0, e_d(),          "bne_d");
    step(0, 4'd2, CL_BR, 0, 0, 0, e_x(0),         "bne_e");
    step(0, 4'd2, CL_BR, 0, 0, 0, e_wb(0, 0),     "bne_wb");
    // ld with ack in first MEM cycle
    step(1, 4'd0, CL_LOAD, 0, 0, 0, e_f(1),       "ld_f");
    step(0, 4'd0, CL_LOAD, 0, 0, 0, e_d(),        "ld_d");
    step(0, 4'd0, CL_LOAD, 0, 0, 0, e_x(0),       "ld_e");
    step(0, 4'd0, CL_LOAD, 0, 0, 1, e_m(0),       "ld_m");
    step(0, 4'd0, CL_LOAD, 0, 0, 0, e_wb(1, 0),   "ld_wb");
    // jal
    step(1, 4'd0, CL_JMP, 0, 0, 0, e_f(1),        "jal_f");
    step(0, 4'd0, CL_JMP, 0, 0, 0, e_d(),         "jal_d");
    step(0, 4'd0, CL_JMP, 0, 0, 0, e_x(0),        "jal_e");
    step(0, 4'd0, CL_JMP, 0, 0, 0, e_wb(1, 1),    "jal_wb");
    // ctrl 15 with a branch flag is legal
    step(1, 4'hF, CL_BR, 0, 0, 0, e_f(1),         "c15br_f");
    step(0, 4'hF, CL_BR, 0, 0, 0, e_d(),          "c15br_d");
    step(0, 4'hF, CL_BR, 0, 0, 0, e_x(0),         "c15br_e");
    step(0, 4'hF, CL_BR, 0, 0, 0, e_wb(0, 0),     "c15br_wb");
    // ebreak, then ifu_valid pulses while halted
    step(1, 4'd0, CL_EBR, 0, 0, 0, e_f(1),        "ebr_f");
    step(0, 4'd0, CL_EBR, 0, 0, 0, e_d(),         "ebr_d");
    step(1, 4'd0, CL_NONE, 0, 0, 0, e_h(2'd0),    "ebr_h1");
    step(0, 4'd0, CL_NONE, 0, 0, 0, e_h(2'd0),    "ebr_h2");
    step(1, 4'd0, CL_NONE, 0, 0, 0, e_h(2'd0),    "ebr_h3");

    // illegal instruction
    do_reset(1'b0);
    step(1, 4'hF, CL_NONE, 0, 0, 0, e_f(1),       "ill_f");
    step(0, 4'hF, CL_NONE, 0, 0, 0, e_d(),        "ill_d");
    step(0, 4'hF, CL_NONE, 0, 0, 0, e_h(2'd1),    "ill_h1");
    step(1, 4'd0, CL_NONE, 0, 0, 0, e_h(2'd1),    "ill_h2");

    // FETCH watchdog: eighth waiting cycle expires
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) step(0, 4'd0, CL_NONE, 0, 0, 0, e_f(0), "to_wait");
    step(0, 4'd0, CL_NONE, 0, 0, 0, e_h(2'd2),    "to_halt");
    step(0, 4'd0, CL_NONE, 0, 0, 0, e_h(2'd2),    "to_hold");

    // handshake on the expiry cycle wins
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) step(0, 4'd0, CL_NONE, 0, 0, 0, e_f(0), "tie_wait");
    step(1, 4'd0, CL_NONE, 0, 0, 0, e_f(1),       "tie_f");
    step(0, 4'd0, CL_NONE, 0, 0, 0, e_d(),        "tie_d");
    step(0, 4'd0, CL_NONE, 0, 0, 0, e_x(0),       "tie_e");
    step(0, 4'd0, CL_NONE, 0, 0, 0, e_wb(1, 0),   "tie_wb");

    // reset in the middle of a store's MEM phase
    step(1, 4'd0, CL_STORE, 0, 0, 0, e_f(1),      "mm_f");
    step(0, 4'd0, CL_STORE, 0, 0, 0, e_d(),       "mm_d");
    step(0, 4'd0, CL_STORE, 0, 0, 0, e_x(0),      "mm_e");
    @(posedge clk);
    #1;
    chk("mm_lsu_req_before", {63'd0, lsu_req}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mm_lsu_req_drop", {63'd0, lsu_req}, 64'd0);
    chk("mm_state_rst", {61'd0, state_o}, 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    {is_load, is_store, is_branch, is_jump, is_ebreak} = CL_NONE;
    @(posedge clk);
    #1;
    chk("mm_after_state", {61'd0, state_o}, 64'd0);
    chk("mm_after_ifu_req", {63'd0, ifu_req}, 64'd1);

`ifdef EXEC_SEQ_PERF_EN
    // three back-to-back addi from reset
    do_reset(1'b1);
    repeat (12) @(posedge clk);
    #1;
    chk("perf_instret", instret_cnt, 64'd3);
    chk("perf_cycle", cycle_cnt, 64'd12);
    ifu_valid = 1'b0;
`endif

    repeat (2) @(negedge clk);
    chk("sb_drain", {32'd0, 32'(exp_q.size())}, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
